// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 16:1 bit mux.
// Grant tenure is bounded by MAX_HOLD whenever another eligible requester is waiting.
module mux16_rr_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] req,
   input  logic        cfg_we,
   input  logic [15:0] cfg_data,
   output logic [3:0]  sel,
   output logic [15:0] gnt,
   output logic        busy,
   output logic [15:0] mask
);

   localparam int CW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t         state_r, state_nxt_s;
   logic [3:0]     ptr_r, ptr_nxt_s;
   logic [CW-1:0]  cnt_r, cnt_nxt_s;
   logic [3:0]     sel_r, sel_nxt_s;
   logic [15:0]    gnt_r, gnt_nxt_s;
   logic           busy_r, busy_nxt_s;
   logic [15:0]    mask_r;
   logic [15:0]    elig_s, owner_oh_s, others_s;
   logic           release_s;
   logic [4:0]     pick_idle_s, pick_hand_s;

   // First set bit of vec scanning start+1, start+2, ... wrapping at 16; bit 4 flags a hit.
   function automatic logic [4:0] rr_pick(input logic [15:0] vec, input logic [3:0] start);
      logic [4:0] res;
      logic [3:0] idx;
      res = 5'd0;
      for (int i = 1; i <= 16; i++) begin
         idx = start + i[3:0];
         if (!res[4] && vec[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   assign elig_s      = req & mask_r;
   assign owner_oh_s  = 16'h0001 << sel_r;
   assign others_s    = elig_s & ~owner_oh_s;
   assign pick_idle_s = rr_pick(elig_s, ptr_r);
   assign pick_hand_s = rr_pick(others_s, sel_r);
   // Release order mirrors priority: disable, owner drop or mask-out, then hold expiry.
   assign release_s   = !en || !req[sel_r] || !mask_r[sel_r] ||
                        ((cnt_r == HOLD_LIMIT) && (others_s != 16'h0000));

   // Next-state and next-output decode for the grant FSM.
   always_comb begin
      state_nxt_s = state_r;
      ptr_nxt_s   = ptr_r;
      cnt_nxt_s   = cnt_r;
      sel_nxt_s   = sel_r;
      case (state_r)
         IDLE: begin
            if (en && pick_idle_s[4]) begin
               state_nxt_s = GRANT;
               sel_nxt_s   = pick_idle_s[3:0];
               cnt_nxt_s   = CW'(1'b1);
            end else begin
               state_nxt_s = IDLE;
            end
         end
         GRANT: begin
            if (release_s) begin
               ptr_nxt_s = sel_r;
               if (en && pick_hand_s[4]) begin
                  state_nxt_s = GRANT;
                  sel_nxt_s   = pick_hand_s[3:0];
                  cnt_nxt_s   = CW'(1'b1);
               end else begin
                  state_nxt_s = IDLE;
                  cnt_nxt_s   = '0;
               end
            end else if (cnt_r != HOLD_LIMIT) begin
               cnt_nxt_s = cnt_r + CW'(1'b1);
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
         end
      endcase
      busy_nxt_s = (state_nxt_s == GRANT);
      if (busy_nxt_s) begin
         gnt_nxt_s = 16'h0001 << sel_nxt_s;
      end else begin
         gnt_nxt_s = 16'h0000;
      end
   end

   // State, pointer, counter, mask and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         ptr_r   <= 4'd15;
         cnt_r   <= '0;
         sel_r   <= 4'd0;
         gnt_r   <= 16'h0000;
         busy_r  <= 1'b0;
         mask_r  <= 16'hFFFF;
      end else begin
         state_r <= state_nxt_s;
         ptr_r   <= ptr_nxt_s;
         cnt_r   <= cnt_nxt_s;
         sel_r   <= sel_nxt_s;
         gnt_r   <= gnt_nxt_s;
         busy_r  <= busy_nxt_s;
         if (cfg_we) begin
            mask_r <= cfg_data;
         end else begin
            mask_r <= mask_r;
         end
      end
   end

   assign sel  = sel_r;
   assign gnt  = gnt_r;
   assign busy = busy_r;
   assign mask = mask_r;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed and randomized bench for mux16_rr_arbiter with a behavioural model of the scheduling rules.
module tb_mux16_rr_arbiter;

   localparam int MAXH = 4;

   logic        clk;
   logic        rst;
   logic        en;
   logic [15:0] req;
   logic        cfg_we;
   logic [15:0] cfg_data;
   logic [3:0]  sel;
   logic [15:0] gnt;
   logic        busy;
   logic [15:0] mask;

   int n_pass;
   int n_total;

   // model state: owner index, last owner pointer, tenure and mask
   int          m_sel;
   int          m_ptr;
   int          m_cnt;
   logic        m_busy;
   logic [15:0] m_mask;

   mux16_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .req      (req),
      .cfg_we   (cfg_we),
      .cfg_data (cfg_data),
      .sel      (sel),
      .gnt      (gnt),
      .busy     (busy),
      .mask     (mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int rr_find(input logic [15:0] v, input int p);
      for (int k = 1; k <= 16; k++) begin
         if (v[(p + k) % 16]) return (p + k) % 16;
      end
      return -1;
   endfunction

   task automatic model_edge();
      logic [15:0] elig;
      logic [15:0] others;
      bit          rel;
      int          w;
      if (rst) begin
         m_sel = 0; m_ptr = 15; m_cnt = 0; m_busy = 1'b0; m_mask = 16'hFFFF;
      end else begin
         elig = req & m_mask;
         if (!m_busy) begin
            w = rr_find(elig, m_ptr);
            if (en && w >= 0) begin
               m_sel = w; m_busy = 1'b1; m_cnt = 1;
            end
         end else begin
            others = elig;
            others[m_sel] = 1'b0;
            rel = !en || !req[m_sel] || !m_mask[m_sel] || (m_cnt == MAXH && others != 16'h0000);
            if (rel) begin
               m_ptr = m_sel;
               if (en && others != 16'h0000) begin
                  m_sel = rr_find(others, m_sel); m_cnt = 1;
               end else begin
                  m_busy = 1'b0; m_cnt = 0;
               end
            end else if (m_cnt < MAXH) begin
               m_cnt = m_cnt + 1;
            end
         end
         if (cfg_we) m_mask = cfg_data;
      end
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [15:0] eg;
      eg = m_busy ? (16'h0001 << m_sel) : 16'h0000;
      check({tag, ".gnt"}, gnt, eg);
      check({tag, ".sel"}, {12'h000, sel}, 16'(m_sel));
      check({tag, ".busy"}, {15'h0000, busy}, {15'h0000, m_busy});
      check({tag, ".mask"}, mask, m_mask);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_model(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b1; req = 16'hFFFF; cfg_we = 1'b0; cfg_data = 16'h0000;
      step("reset");
      rst = 1'b0; req = 16'h0000;
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      m_sel = 0; m_ptr = 15; m_cnt = 0; m_busy = 1'b0; m_mask = 16'hFFFF;
      rst = 1'b1; en = 1'b0; req = 16'h0000; cfg_we = 1'b0; cfg_data = 16'h0000;
      #2;

      // reset values
      do_reset();
      check("rst_gnt", gnt, 16'h0000);
      check("rst_sel", {12'h000, sel}, 16'h0000);
      check("rst_busy", {15'h0000, busy}, 16'h0000);
      check("rst_mask", mask, 16'hFFFF);

      // single request, then drop
      req = 16'h0020; step("single");
      check("single_gnt", gnt, 16'h0020);
      check("single_sel", {12'h000, sel}, 16'h0005);
      req = 16'h0000; step("drop");
      check("drop_gnt", gnt, 16'h0000);
      check("drop_busy", {15'h0000, busy}, 16'h0000);
      check("drop_sel", {12'h000, sel}, 16'h0005);

      // hold-limit rotation between 0 and 15, no bubble
      do_reset();
      req = 16'h8001;
      for (int i = 0; i < 16; i++) begin
         step("rot");
         check("rot_gnt", gnt, ((i / MAXH) % 2 == 0) ? 16'h0001 : 16'h8000);
      end

      // owner drop hands over back-to-back
      do_reset();
      req = 16'h0008; step("own3");
      check("own3_gnt", gnt, 16'h0008);
      req = 16'h0088; step("own3_hold");
      check("own3_hold_gnt", gnt, 16'h0008);
      req = 16'h0080; step("hand7");
      check("hand7_gnt", gnt, 16'h0080);
      check("hand7_sel", {12'h000, sel}, 16'h0007);

      // wrap from pointer 15
      do_reset();
      req = 16'h8000; step("w15");
      check("w15_gnt", gnt, 16'h8000);
      req = 16'h0000; step("w15_rel");
      req = 16'h8004; step("wrap2");
      check("wrap2_gnt", gnt, 16'h0004);
      for (int i = 0; i < MAXH - 1; i++) begin
         step("wrap2_hold");
         check("wrap2_hold_gnt", gnt, 16'h0004);
      end
      step("wrap15");
      check("wrap15_gnt", gnt, 16'h8000);

      // mask out the owner
      do_reset();
      req = 16'h0200; step("own9");
      check("own9_gnt", gnt, 16'h0200);
      cfg_we = 1'b1; cfg_data = 16'hFDFF; step("mask_wr");
      check("mask_wr_gnt", gnt, 16'h0200);
      check("mask_rb", mask, 16'hFDFF);
      cfg_we = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step("masked");
         check("masked_gnt", gnt, 16'h0000);
      end
      cfg_we = 1'b1; cfg_data = 16'hFFFF; step("unmask");
      check("unmask_gnt", gnt, 16'h0000);
      cfg_we = 1'b0; step("regrant9");
      check("regrant9_gnt", gnt, 16'h0200);

      // disable mid-grant, re-enable, then reset mid-grant
      do_reset();
      req = 16'h0010; step("own4");
      check("own4_gnt", gnt, 16'h0010);
      en = 1'b0; step("dis");
      check("dis_gnt", gnt, 16'h0000);
      check("dis_busy", {15'h0000, busy}, 16'h0000);
      en = 1'b1; req = 16'h0011; step("reen");
      check("reen_gnt", gnt, 16'h0001);
      rst = 1'b1; step("rst_mid");
      check("rst_mid_gnt", gnt, 16'h0000);
      check("rst_mid_sel", {12'h000, sel}, 16'h0000);
      rst = 1'b0;

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         req      = 16'($urandom) & 16'($urandom);
         en       = ($urandom_range(0, 9) != 0);
         cfg_we   = ($urandom_range(0, 15) == 0);
         cfg_data = 16'($urandom) | 16'($urandom);
         rst      = ($urandom_range(0, 99) == 0);
         step("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
